// File: rtl/fp32_pkg.sv
// Shared constants, field positions and FSM encoding for the FP32 multiply front end.
package fp32_pkg;

    localparam int EXP_BIAS = 127;
    localparam int EXP_W    = 10;
    localparam int FRAC_W   = 23;

    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int EXP_BITS = EXP_MSB - EXP_LSB + 1;

    typedef enum logic [1:0] {
        GET_A,
        GET_B,
        CALC,
        ISSUE
    } state_t;

endpackage

// File: rtl/fp32_field_split.sv
// Splits one packed FP32 word into sign, biased exponent and hidden-bit mantissa.
module fp32_field_split
    import fp32_pkg::*;
(
    input  logic [31:0]         word,
    output logic                sign,
    output logic [EXP_BITS-1:0] exp,
    output logic [FRAC_W:0]     mant,
    output logic                is_zero
);

    assign sign    = word[SIGN_BIT];
    assign exp     = word[EXP_MSB:EXP_LSB];
    // Denormals have no hidden bit; they are flushed to zero by the caller.
    assign is_zero = (exp == '0);
    assign mant    = {~is_zero, word[FRAC_W-1:0]};

endmodule

// File: rtl/fp32_operand_unpack.sv
// Collects operands A then B over one bus, unpacks them and hands the set to the multiplier.
module fp32_operand_unpack
    import fp32_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      InBus,
    input  logic             InValid,
    output logic             InReady,
    output logic             OpsValid,
    input  logic             OpsReady,
    output logic             SignR,
    output logic [FRAC_W:0]  MantA,
    output logic [FRAC_W:0]  MantB,
    output logic [EXP_W-1:0] Rexp,
    output logic             ZeroFlag,
    output logic             Busy
);

    state_t state, next_state;
    logic   load_a, load_b, load_res;

    logic [31:0] op_a, op_b;

    logic                sign_a, sign_b;
    logic [EXP_BITS-1:0] exp_a, exp_b;
    logic [FRAC_W:0]     mant_a, mant_b;
    logic                zero_a, zero_b;
    logic [EXP_W-1:0]    exp_sum;

    fp32_field_split u_split_a (
        .word    (op_a),
        .sign    (sign_a),
        .exp     (exp_a),
        .mant    (mant_a),
        .is_zero (zero_a)
    );

    fp32_field_split u_split_b (
        .word    (op_b),
        .sign    (sign_b),
        .exp     (exp_b),
        .mant    (mant_b),
        .is_zero (zero_b)
    );

    // Wraps modulo 2^EXP_W, giving the two's complement unbiased sum.
    assign exp_sum = EXP_W'(exp_a) + EXP_W'(exp_b) - EXP_W'(2 * EXP_BIAS);

    // NOTE: state and data registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= GET_A;
        else      state <= next_state;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first; a missed branch would otherwise infer a latch.
        next_state = state;
        load_a     = 1'b0;
        load_b     = 1'b0;
        load_res   = 1'b0;
        unique case (state)
            GET_A: if (InValid) begin
                load_a     = 1'b1;
                next_state = GET_B;
            end
            GET_B: if (InValid) begin
                load_b     = 1'b1;
                next_state = CALC;
            end
            CALC: begin
                load_res   = 1'b1;
                next_state = ISSUE;
            end
            ISSUE: if (OpsReady) next_state = GET_A;
            default: next_state = GET_A;
        endcase
    end

    // NOTE: these are plain flops, not a memory, so clearing them on reset is cheap and keeps outputs defined.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_a     <= '0;
            op_b     <= '0;
            SignR    <= 1'b0;
            MantA    <= '0;
            MantB    <= '0;
            Rexp     <= '0;
            ZeroFlag <= 1'b0;
        end else begin
            if (load_a) op_a <= InBus;
            if (load_b) op_b <= InBus;
            if (load_res) begin
                SignR    <= sign_a ^ sign_b;
                ZeroFlag <= zero_a | zero_b;
                MantA    <= (zero_a | zero_b) ? '0 : mant_a;
                MantB    <= (zero_a | zero_b) ? '0 : mant_b;
                Rexp     <= (zero_a | zero_b) ? '0 : exp_sum;
            end
        end
    end

    // Decoded from the state register alone, so both track the post-edge state.
    assign InReady  = (state == GET_A) || (state == GET_B);
    assign OpsValid = (state == ISSUE);
    assign Busy     = (state != GET_A);

endmodule
